// File: rtl/ebr_pingpong_ctrl.sv
// Ping-pong controller for a 2*FRAME_LEN deep block RAM: the writer fills one bank
// while the reader drains the other, and frames are read back in the order written.
module ebr_pingpong_ctrl #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 512,
  localparam int AW       = $clog2(2 * FRAME_LEN)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_wr_abort,
  output logic [WIDTH-1:0] o_ram_wr_data,
  output logic [AW-1:0]    o_ram_wr_addr,
  output logic             o_ram_wr_valid,
  output logic [AW-1:0]    o_ram_rd_addr,
  output logic             o_ram_rd_addr_valid,
  input  logic             i_ram_rd_addr_ready,
  output logic             o_rd_last,
  output logic [1:0]       o_frames_buffered,
  output logic             o_wr_frame_done,
  output logic             o_rd_frame_done
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] BANK_OFS = AW'(FRAME_LEN);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             wr_valid_q, wr_valid_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;

  logic accept;
  logic rd_fire;
  logic wr_last;
  logic rd_last;

  assign o_in_ready          = !full_q[wr_bank_q] && !i_wr_abort;
  assign o_ram_rd_addr_valid = full_q[rd_bank_q];
  assign o_ram_rd_addr       = rd_bank_q ? (BANK_OFS + AW'(rd_cnt_q)) : AW'(rd_cnt_q);
  assign o_rd_last           = rd_last && o_ram_rd_addr_valid;
  assign o_frames_buffered   = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};
  assign o_ram_wr_valid      = wr_valid_q;
  assign o_ram_wr_data       = wr_data_q;
  assign o_ram_wr_addr       = wr_addr_q;
  assign o_wr_frame_done     = wr_done_q;
  assign o_rd_frame_done     = rd_done_q;

  assign accept  = i_in_valid && o_in_ready;
  assign rd_fire = o_ram_rd_addr_valid && i_ram_rd_addr_ready;
  assign wr_last = (wr_cnt_q == CNT_LAST);
  assign rd_last = (rd_cnt_q == CNT_LAST);

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_valid_d = accept;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;

    // Abort only rewinds the fill pointer; o_in_ready is already low so nothing is accepted.
    if (i_wr_abort) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      wr_data_d = i_in_data;
      wr_addr_d = wr_bank_q ? (BANK_OFS + AW'(wr_cnt_q)) : AW'(wr_cnt_q);
      if (wr_last) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_done_d         = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // The read bank is full and the write bank is not, so set and clear never collide.
    if (rd_fire) begin
      if (rd_last) begin
        rd_cnt_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_done_d         = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
    end
  end

endmodule

// File: tb/tb_ebr_pingpong_ctrl.sv
// Directed bench for ebr_pingpong_ctrl with FRAME_LEN=4, WIDTH=8; expectations are hand-computed.
module tb_ebr_pingpong_ctrl;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int AW        = $clog2(2 * FRAME_LEN);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             wr_abort;
  logic [WIDTH-1:0] ram_wr_data;
  logic [AW-1:0]    ram_wr_addr;
  logic             ram_wr_valid;
  logic [AW-1:0]    ram_rd_addr;
  logic             ram_rd_addr_valid;
  logic             ram_rd_addr_ready;
  logic             rd_last;
  logic [1:0]       frames_buffered;
  logic             wr_frame_done;
  logic             rd_frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ebr_pingpong_ctrl #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_in_data           (in_data),
    .i_in_valid          (in_valid),
    .o_in_ready          (in_ready),
    .i_wr_abort          (wr_abort),
    .o_ram_wr_data       (ram_wr_data),
    .o_ram_wr_addr       (ram_wr_addr),
    .o_ram_wr_valid      (ram_wr_valid),
    .o_ram_rd_addr       (ram_rd_addr),
    .o_ram_rd_addr_valid (ram_rd_addr_valid),
    .i_ram_rd_addr_ready (ram_rd_addr_ready),
    .o_rd_last           (rd_last),
    .o_frames_buffered   (frames_buffered),
    .o_wr_frame_done     (wr_frame_done),
    .o_rd_frame_done     (rd_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Offer one sample, expect it accepted and written one cycle later.
  task automatic push(input logic [7:0] d, input int exp_addr, input bit exp_done);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    chk("push_ready", 32'(in_ready), 32'd1);
    step();
    chk("wr_valid", 32'(ram_wr_valid), 32'd1);
    chk("wr_addr", 32'(ram_wr_addr), 32'(exp_addr));
    chk("wr_data", 32'(ram_wr_data), 32'(d));
    chk("wr_done", 32'(wr_frame_done), 32'(exp_done));
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    wr_abort = 1'b0;
    ram_rd_addr_ready = 1'b0;
    #2;
    do_reset();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rd_valid", 32'(ram_rd_addr_valid), 32'd0);
    chk("rst_frames", 32'(frames_buffered), 32'd0);
    chk("rst_wr_valid", 32'(ram_wr_valid), 32'd0);
    chk("rst_wr_done", 32'(wr_frame_done), 32'd0);
    chk("rst_rd_done", 32'(rd_frame_done), 32'd0);

    // First frame into bank 0
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), i, i == 3);
    chk("f1_frames", 32'(frames_buffered), 32'd1);
    chk("f1_rd_valid", 32'(ram_rd_addr_valid), 32'd1);
    chk("f1_rd_addr", 32'(ram_rd_addr), 32'd0);
    step();
    chk("f1_idle_wr_valid", 32'(ram_wr_valid), 32'd0);
    chk("f1_done_once", 32'(wr_frame_done), 32'd0);

    // Second frame into bank 1, then both full
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 4 + i, i == 3);
    chk("f2_frames", 32'(frames_buffered), 32'd2);
    chk("f2_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h99;
    in_valid = 1'b1;
    step();
    chk("stall_wr_valid", 32'(ram_wr_valid), 32'd0);
    chk("stall_frames", 32'(frames_buffered), 32'd2);
    chk("stall_rd_addr_hold", 32'(ram_rd_addr), 32'd0);
    in_valid = 1'b0;

    // Drain bank 0
    ram_rd_addr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rd_valid", 32'(ram_rd_addr_valid), 32'd1);
      chk("drain_rd_addr", 32'(ram_rd_addr), 32'(i));
      chk("drain_rd_last", 32'(rd_last), 32'(i == 3));
      step();
      chk("drain_rd_done", 32'(rd_frame_done), 32'(i == 3));
    end
    ram_rd_addr_ready = 1'b0;
    #1;
    chk("drain_frames", 32'(frames_buffered), 32'd1);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_next_rd_addr", 32'(ram_rd_addr), 32'd4);

    // Streaming: bank 1 prefilled, write and read every cycle
    for (int k = 0; k < 8; k++) begin
      in_data = 8'(8'h30 + k);
      in_valid = 1'b1;
      ram_rd_addr_ready = 1'b1;
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_rd_addr", 32'(ram_rd_addr), 32'((k < 4) ? (4 + k) : (k - 4)));
      step();
      chk("stream_wr_addr", 32'(ram_wr_addr), 32'(k));
      chk("stream_wr_data", 32'(ram_wr_data), 32'(8'h30 + k));
      chk("stream_frames", 32'(frames_buffered), 32'd1);
      chk("stream_wr_done", 32'(wr_frame_done), 32'(k == 3 || k == 7));
      chk("stream_rd_done", 32'(rd_frame_done), 32'(k == 3 || k == 7));
    end
    in_valid = 1'b0;
    ram_rd_addr_ready = 1'b0;

    // Abort a partial frame
    do_reset();
    push(8'h40, 0, 1'b0);
    push(8'h41, 1, 1'b0);
    wr_abort = 1'b1;
    in_data = 8'h4f;
    in_valid = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("abort_wr_valid", 32'(ram_wr_valid), 32'd0);
    chk("abort_wr_done", 32'(wr_frame_done), 32'd0);
    wr_abort = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i), i, i == 3);
    chk("abort_frames", 32'(frames_buffered), 32'd1);

    // Reset mid-stream discards everything
    do_reset();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i), i, i == 3);
    chk("pre_rst_frames", 32'(frames_buffered), 32'd1);
    do_reset();
    chk("mid_rst_frames", 32'(frames_buffered), 32'd0);
    chk("mid_rst_rd_valid", 32'(ram_rd_addr_valid), 32'd0);
    chk("mid_rst_wr_valid", 32'(ram_wr_valid), 32'd0);
    push(8'h70, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ebr_pingpong_ctrl.md
EBR_PINGPONG_CTRL -- requirements
Module: ebr_pingpong_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the sample width in bits.
REQ-002 The block SHALL have parameter FRAME_LEN, default 512, meaning samples per bank (legal range >= 2); RAM depth = 2*FRAME_LEN, AW = $clog2(2*FRAME_LEN).
REQ-003 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_in_data, input, WIDTH bits: upstream sample.
REQ-006 The block SHALL have port i_in_valid, input, 1 bit: upstream sample valid.
REQ-007 The block SHALL have port o_in_ready, output, 1 bit: block accepts a sample.
REQ-008 The block SHALL have port i_wr_abort, input, 1 bit: discard the partially written frame.
REQ-009 The block SHALL have port o_ram_wr_data, output, WIDTH bits: RAM write data.
REQ-010 The block SHALL have port o_ram_wr_addr, output, AW bits: RAM write address.
REQ-011 The block SHALL have port o_ram_wr_valid, output, 1 bit: RAM write strobe.
REQ-012 The block SHALL have port o_ram_rd_addr, output, AW bits: RAM read address.
REQ-013 The block SHALL have port o_ram_rd_addr_valid, output, 1 bit: RAM read address valid.
REQ-014 The block SHALL have port i_ram_rd_addr_ready, input, 1 bit: RAM accepts the read address.
REQ-015 The block SHALL have port o_rd_last, output, 1 bit: the current read address is the last of its frame.
REQ-016 The block SHALL have port o_frames_buffered, output, 2 bits: count of full banks (0..2).
REQ-017 The block SHALL have port o_wr_frame_done, output, 1 bit: one-cycle pulse when a bank completes filling.
REQ-018 The block SHALL have port o_rd_frame_done, output, 1 bit: one-cycle pulse when a bank is fully read.

Function
REQ-019 State SHALL be held in: full[1:0], wr_bank, rd_bank, wr_cnt, rd_cnt (counters 0..FRAME_LEN-1).
REQ-020 o_in_ready SHALL equal !full[wr_bank] && !i_wr_abort, decoded combinationally from registers and that input.
REQ-021 A sample SHALL be accepted in any cycle where i_in_valid && o_in_ready.
REQ-022 On acceptance, o_ram_wr_valid SHALL be 1 on the next cycle, with o_ram_wr_data = the accepted sample and o_ram_wr_addr = wr_bank*FRAME_LEN + wr_cnt (all registered, latency 1); otherwise o_ram_wr_valid SHALL be 0.
REQ-023 On acceptance, wr_cnt SHALL increment; when wr_cnt == FRAME_LEN-1, wr_cnt SHALL wrap to 0, full[wr_bank] SHALL set, wr_bank SHALL toggle, and o_wr_frame_done SHALL pulse on the next cycle.
REQ-024 While i_wr_abort == 1, wr_cnt SHALL clear to 0, wr_bank and full SHALL remain unchanged, and no write SHALL occur; the bank is overwritten from offset 0 afterwards.
REQ-025 o_ram_rd_addr_valid SHALL equal full[rd_bank], with o_ram_rd_addr = rd_bank*FRAME_LEN + rd_cnt and o_rd_last = (rd_cnt == FRAME_LEN-1) && o_ram_rd_addr_valid.
REQ-026 o_ram_rd_addr and o_ram_rd_addr_valid SHALL hold stable until i_ram_rd_addr_ready.
REQ-027 On the read handshake, rd_cnt SHALL increment; on the last address, rd_cnt SHALL wrap to 0, full[rd_bank] SHALL clear, rd_bank SHALL toggle, and o_rd_frame_done SHALL pulse on the next cycle.
REQ-028 When a bank-set on one bank and a bank-clear on the other occur in the same cycle, both SHALL take effect and o_frames_buffered SHALL be unchanged.
REQ-029 The writer SHALL never write to a bank whose full bit is set, and the reader SHALL never issue an address from a bank whose full bit is clear.
REQ-030 Read order SHALL equal write order: frames are read FIFO-fashion, alternating banks starting at bank 0.
REQ-031 Throughput SHALL be one write and one read address per cycle, concurrently.

Reset
REQ-032 When i_reset == 1 at a clock edge, full, wr_bank, rd_bank, wr_cnt and rd_cnt SHALL be 0, and o_ram_wr_valid, o_wr_frame_done and o_rd_frame_done SHALL be 0 on the next cycle.
REQ-033 After reset, o_in_ready SHALL be 1 (absent i_wr_abort), o_ram_rd_addr_valid SHALL be 0, and o_frames_buffered SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL discard all buffered and partial frames; RAM contents are not cleared.

Verification (FRAME_LEN=4, WIDTH=8)
REQ-035 Reset, then stream 0x10..0x13 with rd ready=0 -> writes to addr 0..3; o_wr_frame_done pulses once; o_frames_buffered=1; rd_addr_valid=1, addr 0.
REQ-036 Stream 8 samples with rd ready=0 -> banks fill to addr 7; o_frames_buffered=2; o_in_ready=0; a 9th valid is stalled with no write.
REQ-037 Both banks full, then rd ready=1 for 4 cycles -> rd addr 0,1,2,3 with o_rd_last on 3; o_rd_frame_done pulses; o_in_ready returns to 1; next write goes to addr 0.
REQ-038 Continuous valid and ready after one frame prefilled -> sustained 1 write/cycle and 1 read/cycle; o_frames_buffered stays 1 across the simultaneous set/clear.
REQ-039 Write 2 samples, assert i_wr_abort for 1 cycle, then write 4 -> writes land at addr 0,1, then 0..3; exactly one o_wr_frame_done.
REQ-040 Assert reset after 6 writes -> o_frames_buffered=0, rd_addr_valid=0, and the next write goes to addr 0.
